// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N_CH event counters with a snapshot bank and a
// registered snapshot read port.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   reset     asynchronous, active-high reset
//   enable    global count enable
//   events    per-channel event pulse, one bit per channel
//   clear     synchronous clear of live counters and overflow flags
//   snap      copy every live counter into the snapshot bank
//   rd_en     snapshot read request
//   rd_sel    channel index to read
//   rd_data   registered snapshot value (1-cycle latency)
//   rd_valid  rd_data was updated this cycle
//   overflow  per-channel sticky overflow flag
//
// The per-channel event input is named "events" because "event" is a
// reserved word in SystemVerilog.

// One channel: live counter, sticky overflow flag and snapshot register.
module perf_counter_lane #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  input  logic             snap,
  output logic [WIDTH-1:0] snap_q,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      ovf    <= 1'b0;
      snap_q <= '0;
    end else begin
      // Snapshot sees the pre-edge count, so snap+clear captures pre-clear values.
      if (snap) snap_q <= cnt;
      if (clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (&cnt) begin
          ovf <= 1'b1;
          cnt <= (SATURATE != 0) ? cnt : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

module perf_counter_bank #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic [N_CH-1:0]                            events,
  input  logic                                       clear,
  input  logic                                       snap,
  input  logic                                       rd_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_sel,
  output logic [WIDTH-1:0]                           rd_data,
  output logic                                       rd_valid,
  output logic [N_CH-1:0]                            overflow
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] sel;
  } rd_req_t;

  logic [N_CH-1:0][WIDTH-1:0] snap_bank;
  logic [WIDTH-1:0]           rd_mux;
  rd_req_t                    req;

  assign req = '{vld: rd_en, sel: rd_sel};

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    perf_counter_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .inc    (enable & events[i]),
      .clear  (clear),
      .snap   (snap),
      .snap_q (snap_bank[i]),
      .ovf    (overflow[i])
    );
  end

  // Selects beyond the last channel read as zero (possible when N_CH is
  // not a power of two).
  always_comb begin
    rd_mux = '0;
    if ({1'b0, req.sel} < N_CH_W) rd_mux = snap_bank[req.sel];
  end

  // Read samples the pre-edge snapshot bank, so a same-cycle snap is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= req.vld;
      if (req.vld) rd_data <= rd_mux;
    end
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of event channels (range 1..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the width of each counter (range 8..64).
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = counters wrap to zero and 1 = counters hold at maximum.
REQ-004 The block SHALL have port clk  input  1  meaning the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  meaning global count enable.
REQ-007 The block SHALL have port event  input  N_CH  meaning per-channel event pulse (e.g. stall, flush, retire, branch taken).
REQ-008 The block SHALL have port clear  input  1  meaning synchronous clear of all live counters and overflow flags.
REQ-009 The block SHALL have port snap  input  1  meaning copy all live counters into the snapshot bank.
REQ-010 The block SHALL have port rd_en  input  1  meaning snapshot read request.
REQ-011 The block SHALL have port rd_sel  input  clog2(N_CH) (minimum 1)  meaning the channel index to read.
REQ-012 The block SHALL have port rd_data  output  WIDTH  meaning the registered snapshot value.
REQ-013 The block SHALL have port rd_valid  output  1  meaning rd_data was updated this cycle.
REQ-014 The block SHALL have port overflow  output  N_CH  meaning per-channel sticky overflow flag.

Function
REQ-015 On each edge, live counter i SHALL increment by 1 when enable=1 and event[i]=1; otherwise it SHALL hold.
REQ-016 Wrap mode (SATURATE=0): an increment at 2^WIDTH-1 SHALL give 0, and overflow[i] SHALL be set to 1.
REQ-017 Saturate mode (SATURATE=1): an increment at 2^WIDTH-1 SHALL hold the value at 2^WIDTH-1, and overflow[i] SHALL be set to 1.
REQ-018 overflow[i] SHALL remain set until clear or reset.
REQ-019 clear=1 SHALL zero all live counters and overflow flags on the next edge, with priority over any same-cycle increment.
REQ-020 clear SHALL NOT modify the snapshot bank.
REQ-021 snap=1 SHALL load snapshot[i] with the live counter register value present before that edge, for all i simultaneously, with no partial update.
REQ-022 When snap=1 and clear=1 in the same cycle, the snapshot SHALL capture the pre-clear values and the live counters SHALL become 0.
REQ-023 rd_en=1 SHALL give rd_data = snapshot[rd_sel] and rd_valid=1 after the next edge (1-cycle latency); rd_valid SHALL be 1 for exactly one cycle per request.
REQ-024 When rd_en=1 and snap=1 in the same cycle, rd_data SHALL return the snapshot value from before that edge.
REQ-025 When rd_sel >= N_CH, rd_data SHALL be 0 and rd_valid SHALL be 1.
REQ-026 When rd_en=0, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-027 Back-to-back reads on consecutive cycles SHALL be accepted with no bubble.
REQ-028 enable=0 SHALL freeze the live counters; clear, snap and read SHALL remain functional while enable=0.

Reset
REQ-029 reset=1 SHALL immediately (asynchronously) zero all live counters, snapshots, overflow, rd_data and rd_valid.
REQ-030 Reset asserted mid-count or mid-read SHALL discard the in-flight read, so that rd_valid=0 on the first edge after release.
REQ-031 The first edge after reset release SHALL count events normally.

Verification
REQ-032 Count scenario, N_CH=4: enable=1, event=4'b0101 for 10 cycles, then snap, then read ch0..3 -> rd_data = 10, 0, 10, 0, with rd_valid high 1 cycle after each rd_en.
REQ-033 Wrap scenario, WIDTH=8, SATURATE=0: 257 events on ch1 -> live count 1, overflow=4'b0010; the same stimulus with SATURATE=1 -> count 255, overflow=4'b0010.
REQ-034 Simultaneous events scenario: live ch2=7, assert snap and clear together -> next read ch2 returns 7, a following snap + read returns 0, overflow=0.
REQ-035 Read/snap collision scenario: snapshot ch0=3, live ch0=9, assert rd_en(sel 0) and snap together -> rd_data=3; a following read -> 9.
REQ-036 Invalid select and freeze scenario: N_CH=3, rd_sel=3 -> rd_data=0, rd_valid=1; enable=0 with event=all ones for 5 cycles -> counters unchanged.
REQ-037 Reset scenario: assert reset asynchronously between edges during a count of 5 -> all outputs 0 immediately, and rd_valid=0 after release.
